// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks a halfword PC, issues two 16-bit reads per
// 32-bit instruction, assembles {hi,lo} and offers it to decode over a
// valid/ready handshake. A one-cycle redirect flushes in-flight work.
module instr_fetch_unit #(
  parameter int                 DATAWIDTH = 16,
  parameter int                 ADDRBUS   = 20,
  parameter logic [ADDRBUS-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDRBUS-1:0]     mem_addr,
  output logic                   mem_oe,
  output logic                   mem_we,
  input  logic [DATAWIDTH-1:0]   mem_do,
  input  logic                   redirect,
  input  logic [ADDRBUS-1:0]     redirect_pc,
  output logic [2*DATAWIDTH-1:0] instr,
  output logic [ADDRBUS-1:0]     instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready
);

  localparam int INSTRWIDTH = 2 * DATAWIDTH;
  // Clears bit 0 so every PC is an even halfword address.
  localparam logic [ADDRBUS-1:0] EVEN_MASK = {{(ADDRBUS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {REQ_HI, REQ_LO, CAP, HOLD} state_t;

  state_t                 state;
  logic [ADDRBUS-1:0]     pc;
  logic [DATAWIDTH-1:0]   hi_reg;
  logic [INSTRWIDTH-1:0]  buf_data;
  logic [ADDRBUS-1:0]     buf_pc;

  // A consumer taking the current instruction this cycle frees the slot.
  logic take;
  assign take = instr_valid && instr_ready;

  assign mem_we = 1'b0;

  // Memory request decode from registered state only; held quiet during reset.
  always_comb begin
    mem_oe   = 1'b0;
    mem_addr = '0;
    if (rst_n) begin
      case (state)
        REQ_HI: begin
          mem_oe   = 1'b1;
          mem_addr = pc;
        end
        REQ_LO: begin
          mem_oe   = 1'b1;
          mem_addr = pc + ADDRBUS'(1);
        end
        default: begin
          mem_oe   = 1'b0;
          mem_addr = pc;
        end
      endcase
    end
  end

  // Fetch FSM: two reads, capture, then either hand off or park until the slot frees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ_HI;
      pc          <= RESET_PC & EVEN_MASK;
      hi_reg      <= '0;
      buf_data    <= '0;
      buf_pc      <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      // Any data still coming back from the old stream is simply never captured.
      state       <= REQ_HI;
      pc          <= redirect_pc & EVEN_MASK;
      hi_reg      <= '0;
      buf_data    <= '0;
      buf_pc      <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        REQ_HI: begin
          if (take) instr_valid <= 1'b0;
          state <= REQ_LO;
        end
        REQ_LO: begin
          if (take) instr_valid <= 1'b0;
          hi_reg <= mem_do;
          state  <= CAP;
        end
        CAP: begin
          buf_data <= {hi_reg, mem_do};
          buf_pc   <= pc;
          pc       <= pc + ADDRBUS'(2);
          if (!instr_valid || instr_ready) begin
            instr       <= {hi_reg, mem_do};
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= REQ_HI;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          // The slot is full in HOLD; a take is immediately backfilled from the buffer.
          if (instr_ready) begin
            instr    <= buf_data;
            instr_pc <= buf_pc;
            state    <= REQ_HI;
          end
        end
        default: state <= REQ_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed boot/stall/redirect/reset scenarios,
// then a randomized ready/redirect run checked against an instruction-stream model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [19:0] mem_addr;
  logic        mem_oe;
  logic        mem_we;
  logic [15:0] mem_do;
  logic        redirect;
  logic [19:0] redirect_pc;
  logic [31:0] instr;
  logic [19:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(
    .DATAWIDTH(16),
    .ADDRBUS  (20),
    .RESET_PC (20'h00000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .mem_do     (mem_do),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: first four words fixed, the rest a simple address hash.
  function automatic logic [15:0] mem_fn(input logic [19:0] a);
    case (a)
      20'h00000: return 16'h2008;
      20'h00001: return 16'h0005;
      20'h00002: return 16'h2009;
      20'h00003: return 16'h000A;
      default:   return a[15:0] ^ {a[19:16], 12'h5A3};
    endcase
  endfunction

  // The instruction at halfword address p is {mem[p], mem[p+1]} with 20-bit wrap.
  function automatic logic [31:0] exp_instr(input logic [19:0] p);
    logic [19:0] p1;
    p1 = p + 20'd1;
    return {mem_fn(p), mem_fn(p1)};
  endfunction

  // Synchronous-read memory: data for the address of cycle n appears in cycle n+1.
  always @(posedge clk) mem_do <= mem_fn(mem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst valid", instr_valid, 0);
    chk("rst oe", mem_oe, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst instr", instr, 0);
    chk("rst instr_pc", instr_pc, 0);
    chk("rst we", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 12);
    if (!instr_valid) chk({tag, " timeout"}, 0, 1);
  endtask

  // Boot sequence from reset release with READY held high.
  task automatic check_boot();
    chk("boot c0 addr", mem_addr, 20'h0);
    chk("boot c0 oe", mem_oe, 1);
    chk("boot c0 valid", instr_valid, 0);
    @(negedge clk);
    chk("boot c1 addr", mem_addr, 20'h1);
    chk("boot c1 oe", mem_oe, 1);
    @(negedge clk);
    chk("boot c2 oe", mem_oe, 0);
    chk("boot c2 valid", instr_valid, 0);
    @(negedge clk);
    chk("boot i0 valid", instr_valid, 1);
    chk("boot i0 instr", instr, 32'h20080005);
    chk("boot i0 pc", instr_pc, 20'h0);
    chk("boot c3 addr", mem_addr, 20'h2);
    @(negedge clk);
    chk("boot c4 addr", mem_addr, 20'h3);
    chk("boot c4 valid", instr_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("boot i1 valid", instr_valid, 1);
    chk("boot i1 instr", instr, 32'h2009000A);
    chk("boot i1 pc", instr_pc, 20'h2);
  endtask

  // Called at a negedge with READY high; pulses redirect and follows the new stream.
  task automatic redir_check(input logic [19:0] tgt);
    logic [19:0] e;
    logic [19:0] e1;
    logic [19:0] e2;
    e  = tgt & 20'hFFFFE;
    e1 = e + 20'd1;
    e2 = e + 20'd2;
    redirect    = 1'b1;
    redirect_pc = tgt;
    @(negedge clk);
    redirect = 1'b0;
    chk("redir valid drop", instr_valid, 0);
    chk("redir addr hi", mem_addr, e);
    chk("redir oe", mem_oe, 1);
    @(negedge clk);
    chk("redir addr lo", mem_addr, e1);
    wait_valid("redir first");
    chk("redir first pc", instr_pc, e);
    chk("redir first instr", instr, exp_instr(e));
    wait_valid("redir second");
    chk("redir second pc", instr_pc, e2);
    chk("redir second instr", instr, exp_instr(e2));
  endtask

  logic [19:0] exp_pc;
  logic [31:0] held_instr;
  logic [19:0] held_pc;
  logic        holding;
  logic        after_redir;
  int          idle;
  logic        rdy;
  logic        rd;
  logic [19:0] tgt;

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;

    // Boot with READY high.
    do_reset();
    check_boot();

    // Stall: READY low parks the unit in HOLD with the first instruction held.
    instr_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    chk("stall first valid", instr_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall hold instr", instr, 32'h20080005);
    end
    chk("stall hold valid", instr_valid, 1);
    chk("stall hold oe", mem_oe, 0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("stall release instr", instr, 32'h2009000A);
    chk("stall release pc", instr_pc, 20'h2);
    chk("stall release valid", instr_valid, 1);
    chk("stall next addr", mem_addr, 20'h4);
    repeat (4) @(negedge clk);
    chk("hold again oe", mem_oe, 0);
    chk("hold again valid", instr_valid, 1);

    // Asynchronous reset between edges while in HOLD.
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", instr_valid, 0);
    chk("async rst oe", mem_oe, 0);
    chk("async rst addr", mem_addr, 0);
    instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_boot();

    // Redirect during the low-half read of the instruction at PC 2.
    do_reset();
    repeat (4) @(negedge clk);
    chk("pre-redir lo addr", mem_addr, 20'h3);
    redir_check(20'h00100);

    // Odd redirect target and wrap at the top of the address space.
    @(negedge clk);
    redir_check(20'h00101);
    @(negedge clk);
    redir_check(20'hFFFFE);

    // Randomized READY and REDIRECT against the instruction-stream model.
    do_reset();
    exp_pc      = 20'h0;
    holding     = 1'b0;
    after_redir = 1'b0;
    idle        = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (holding) begin
        chk("rand stable valid", instr_valid, 1);
        chk("rand stable instr", instr, held_instr);
        chk("rand stable pc", instr_pc, held_pc);
      end
      if (after_redir) chk("rand redir clears valid", instr_valid, 0);
      if (c % 16 == 0) chk("rand we low", mem_we, 0);
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 40) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (20'hFFFFC | 20'($urandom_range(0, 3)))
                                        : 20'($urandom);
      instr_ready = rdy;
      redirect    = rd;
      redirect_pc = tgt;
      if (instr_valid && rdy) begin
        chk("rand xfer pc", instr_pc, exp_pc);
        chk("rand xfer instr", instr, exp_instr(exp_pc));
        exp_pc = exp_pc + 20'd2;
        idle   = 0;
      end else begin
        idle++;
      end
      holding     = instr_valid && !rdy && !rd;
      held_instr  = instr;
      held_pc     = instr_pc;
      after_redir = rd;
      if (rd) begin
        exp_pc = tgt & 20'hFFFFE;
        idle   = 0;
      end
      if (idle > 60) begin
        chk("rand progress", 0, 1);
        idle = 0;
      end
    end
    redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
